admo_axi_ram: RTL and testbench
===============================

ADMO_AXI_RAM -- requirements
Module: admo_axi_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, giving the byte address width; depth = 2^ADDR_WIDTH / STRB_WIDTH words.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, giving the byte-strobe width.
REQ-004 SHALL have parameter ID_WIDTH, default 8, giving the AXI ID width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports s_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  input  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  write address; lock/cache/prot/size ignored.
REQ-008 SHALL have ports s_axi_awvalid input 1, s_axi_awready output 1  AW handshake.
REQ-009 SHALL have ports s_axi_wdata/wstrb/wlast  input  DATA_WIDTH/STRB_WIDTH/1  write data.
REQ-010 SHALL have ports s_axi_wvalid input 1, s_axi_wready output 1  W handshake.
REQ-011 SHALL have ports s_axi_bid/bresp  output  ID_WIDTH/2, s_axi_bvalid output 1, s_axi_bready input 1  write response.
REQ-012 SHALL have ports s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  input  same widths as AW  read address; lock/cache/prot/size ignored.
REQ-013 SHALL have ports s_axi_arvalid input 1, s_axi_arready output 1  AR handshake.
REQ-014 SHALL have ports s_axi_rid/rdata/rresp/rlast  output  ID_WIDTH/DATA_WIDTH/2/1, s_axi_rvalid output 1, s_axi_rready input 1  read data.

Function
REQ-015 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE.
REQ-016 AW handshake in W_IDLE SHALL latch awid, word address, awlen, awburst, clear beat counter, go to W_DATA next cycle.
REQ-017 In W_DATA wready SHALL be 1; each W handshake writes byte lanes with wstrb=1 at current word, others untouched.
REQ-018 After each write beat, word address SHALL increment by 1 for INCR and WRAP (WRAP treated as INCR), hold for FIXED.
REQ-019 Burst length SHALL be awlen+1 beats by counter; wlast SHALL NOT affect framing.
REQ-020 After the final beat SHALL enter W_RESP with bvalid=1, bid=latched awid, bresp=2'b00, held until bready; then W_IDLE.
REQ-021 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE; AR handshake latches arid, address, arlen, arburst.
REQ-022 First rvalid SHALL assert the cycle after AR handshake; rid=latched arid, rresp=2'b00, rlast=1 only on beat arlen.
REQ-023 rdata/rlast SHALL stay stable while rvalid=1 and rready=0; with rready held high, beats SHALL issue every cycle without bubbles.
REQ-024 After last R handshake SHALL return to R_IDLE; arready=1 the next cycle.
REQ-025 Word index SHALL be addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]; low address bits ignored; increment wraps modulo depth.
REQ-026 Read and write channels SHALL operate concurrently; same-cycle read and write of one word SHALL return pre-write data.

Reset
REQ-027 rst low SHALL asynchronously force awready, wready, bvalid, arready, rvalid, rlast to 0 and both FSMs to idle; bid/rid/rdata/bresp/rresp to 0.
REQ-028 Memory array SHALL NOT be reset; contents retained across reset, in-flight bursts dropped.
REQ-029 First cycle after rst high SHALL present awready=1 and arready=1.

Structure
REQ-030 Shared package admo_pkg SHALL hold AXI burst encodings (FIXED/INCR/WRAP), resp OKAY, and FSM state enums.
REQ-031 Storage SHALL be sub-module admo_ram_dp: one byte-enabled write port, one synchronous read port, inferable as block RAM.

Verification
REQ-032 Write 0x0010 len 0 data 0xDEADBEEF strb 0xF, awid 5 -> bid 5, bresp 0; read 0x0010 arid 7 -> rdata 0xDEADBEEF, rid 7, rlast 1.
REQ-033 INCR len 3 at 0x0100 data 1,2,3,4; read back with rready toggling -> 1,2,3,4 stable under stall, rlast on 4th only.
REQ-034 Write 0x11223344 then strb 4'b0101 data 0xAABBCCDD same address -> read 0x11BB33DD.
REQ-035 FIXED len 2 at 0x0200 data A,B,C -> 0x0200 reads C, 0x0204 unchanged.
REQ-036 INCR len 1 at 0xFFFC -> second beat lands at 0x0000.
REQ-037 rst low mid read burst -> rvalid/arready 0 immediately; after release arready 1, earlier written data still readable.

Source files
------------

// File: rtl/admo_pkg.sv
// Shared definitions for the admo AXI RAM: AXI burst/resp encodings
// and the write/read channel state enums.
`timescale 1ns/1ps
package admo_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/admo_ram_dp.sv
// Dual-port word RAM: byte-enabled write port, registered read port.
// Ports: clk, we/waddr/wstrb/wdata (write), re/raddr/rdata (read-first).
`timescale 1ns/1ps
module admo_ram_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int WORD_AW    = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_AW-1:0]    waddr,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [WORD_AW-1:0]    raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**WORD_AW];

    // Contents survive reset, so no reset term here.
    // Read and write share one process: a same-cycle collision returns old data.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/admo_axi_ram.sv
// AXI4 slave RAM with independent write (AW/W/B) and read (AR/R) FSMs.
// Ports: clk, rst (async active-low), full AXI4 slave channel set.
`timescale 1ns/1ps
module admo_axi_ram
    import admo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int SHIFT = $clog2(STRB_WIDTH);
    localparam int WAW   = ADDR_WIDTH - SHIFT;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [WAW-1:0]        w_addr;
    logic [WAW-1:0]        r_addr;
    logic [WAW-1:0]        r_next;
    logic [WAW-1:0]        ram_raddr;
    logic [7:0]            w_len, w_cnt;
    logic [7:0]            r_len, r_cnt;
    logic [1:0]            w_burst, r_burst;
    logic [ID_WIDTH-1:0]   b_id, r_id;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  ram_re;
    logic                  unused_ok;

    // Gating with rst keeps the ready outputs low while reset is held,
    // yet lets them rise in the very first cycle after release.
    assign s_axi_awready = rst && (w_state == W_IDLE);
    assign s_axi_wready  = (w_state == W_DATA);
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_bid     = b_id;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = rst && (r_state == R_IDLE);
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rid     = r_id;
    assign s_axi_rresp   = RESP_OKAY;
    assign s_axi_rlast   = r_last;
    assign s_axi_rdata   = s_axi_rvalid ? ram_q : '0;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign b_hs  = s_axi_bvalid  && s_axi_bready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid  && s_axi_rready;

    // The RAM is read one beat ahead: at AR accept and at each
    // non-final R accept. While stalled the RAM output simply holds.
    assign r_next    = (r_burst == BURST_FIXED) ? r_addr : r_addr + WAW'(1);
    assign ram_re    = ar_hs || (r_hs && !r_last);
    assign ram_raddr = ar_hs ? s_axi_araddr[ADDR_WIDTH-1:SHIFT] : r_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= BURST_INCR;
            b_id    <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: if (aw_hs) begin
                    b_id    <= s_axi_awid;
                    w_addr  <= s_axi_awaddr[ADDR_WIDTH-1:SHIFT];
                    w_len   <= s_axi_awlen;
                    w_burst <= s_axi_awburst;
                    w_cnt   <= '0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_cnt <= w_cnt + 8'd1;
                    if (w_burst != BURST_FIXED) w_addr <= w_addr + WAW'(1);
                    if (w_cnt == w_len) w_state <= W_RESP;
                end
                W_RESP: if (b_hs) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= BURST_INCR;
            r_id    <= '0;
            r_last  <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_id    <= s_axi_arid;
                    r_addr  <= s_axi_araddr[ADDR_WIDTH-1:SHIFT];
                    r_len   <= s_axi_arlen;
                    r_burst <= s_axi_arburst;
                    r_cnt   <= '0;
                    r_last  <= (s_axi_arlen == 8'd0);
                    r_state <= R_DATA;
                end
                R_DATA: if (r_hs) begin
                    if (r_last) begin
                        r_last  <= 1'b0;
                        r_state <= R_IDLE;
                    end else begin
                        r_addr <= r_next;
                        r_cnt  <= r_cnt + 8'd1;
                        r_last <= ((r_cnt + 8'd1) == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    admo_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .WORD_AW    (WAW)
    ) u_ram (
        .clk   (clk),
        .we    (w_hs),
        .waddr (w_addr),
        .wstrb (s_axi_wstrb),
        .wdata (s_axi_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Sideband fields the RAM has no use for.
    assign unused_ok = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache,
                         s_axi_awprot, s_axi_wlast, s_axi_arsize,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot,
                         s_axi_awaddr[SHIFT-1:0], s_axi_araddr[SHIFT-1:0]};

endmodule

// File: tb/tb_admo_axi_ram.sv
// Directed self-checking bench for admo_axi_ram.
// Scenario tasks run in sequence from one initial block.
`timescale 1ns/1ps
module tb_admo_axi_ram;

    logic        clk = 0;
    logic        rst = 0;
    logic [7:0]  s_axi_awid = 0;
    logic [15:0] s_axi_awaddr = 0;
    logic [7:0]  s_axi_awlen = 0;
    logic [2:0]  s_axi_awsize = 3'd2;
    logic [1:0]  s_axi_awburst = 2'b01;
    logic        s_axi_awlock = 0;
    logic [3:0]  s_axi_awcache = 0;
    logic [2:0]  s_axi_awprot = 0;
    logic        s_axi_awvalid = 0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = 0;
    logic [3:0]  s_axi_wstrb = 0;
    logic        s_axi_wlast = 0;
    logic        s_axi_wvalid = 0;
    logic        s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 0;
    logic [7:0]  s_axi_arid = 0;
    logic [15:0] s_axi_araddr = 0;
    logic [7:0]  s_axi_arlen = 0;
    logic [2:0]  s_axi_arsize = 3'd2;
    logic [1:0]  s_axi_arburst = 2'b01;
    logic        s_axi_arlock = 0;
    logic [3:0]  s_axi_arcache = 0;
    logic [2:0]  s_axi_arprot = 0;
    logic        s_axi_arvalid = 0;
    logic        s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 0;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] wd [8];
    logic [3:0]  ws [8];
    logic [31:0] rd_data [8];
    logic [7:0]  rd_id [8];
    logic        rd_last [8];
    logic [1:0]  rd_resp [8];
    logic [7:0]  got_bid;
    logic [1:0]  got_bresp;
    int          unstable, lat, cycles;

    always #5 clk = ~clk;

    admo_axi_ram dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic do_write(input logic [15:0] addr, input logic [7:0] id,
                            input logic [7:0] len, input logic [1:0] burst);
        int t;
        s_axi_awaddr = addr; s_axi_awid = id;
        s_axi_awlen = len; s_axi_awburst = burst; s_axi_awvalid = 1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_awready && t < 50);
        @(posedge clk); #1 s_axi_awvalid = 0;
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wdata = wd[b]; s_axi_wstrb = ws[b];
            s_axi_wlast = (b == int'(len)); s_axi_wvalid = 1;
            do begin @(negedge clk); t++; end while (!s_axi_wready && t < 50);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 0; s_axi_wlast = 0; s_axi_bready = 1;
        do begin @(negedge clk); t++; end while (!s_axi_bvalid && t < 50);
        got_bid = s_axi_bid; got_bresp = s_axi_bresp;
        @(posedge clk); #1 s_axi_bready = 0;
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout addr %h: waited %0d cycles, required < 50", addr, t);
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] id,
                           input logic [7:0] len, input logic [1:0] burst,
                           input bit toggle);
        int t, b, cyc;
        bit held;
        logic [31:0] hd;
        logic hl;
        s_axi_araddr = addr; s_axi_arid = id;
        s_axi_arlen = len; s_axi_arburst = burst; s_axi_arvalid = 1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_arready && t < 50);
        @(posedge clk); #1 s_axi_arvalid = 0;
        b = 0; cyc = 0; held = 0; unstable = 0; lat = -1; hd = 0; hl = 0;
        while (b <= int'(len) && cyc < 200) begin
            s_axi_rready = toggle ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            if (s_axi_rvalid) begin
                if (lat < 0) lat = cyc;
                if (held && (s_axi_rdata !== hd || s_axi_rlast !== hl))
                    unstable++;
                if (s_axi_rready) begin
                    rd_data[b] = s_axi_rdata; rd_id[b] = s_axi_rid;
                    rd_last[b] = s_axi_rlast; rd_resp[b] = s_axi_rresp;
                    b++; held = 0;
                end else begin
                    held = 1; hd = s_axi_rdata; hl = s_axi_rlast;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_axi_rready = 0;
        cycles = cyc;
        if (t >= 50 || b <= int'(len)) begin
            n_checks++; n_fail++;
            $display("FAIL read_timeout addr %h: got %0d beats, required %0d", addr, b, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid,
             s_axi_arready, s_axi_rvalid, s_axi_rlast} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                {s_axi_awready, s_axi_wready, s_axi_bvalid,
                 s_axi_arready, s_axi_rvalid, s_axi_rlast});
        end
        n_checks++;
        if ({s_axi_bid, s_axi_rid, s_axi_rdata, s_axi_bresp, s_axi_rresp} !== 52'b0) begin
            n_fail++;
            $display("FAIL reset_data: bid %h rid %h rdata %h, required zeros",
                s_axi_bid, s_axi_rid, s_axi_rdata);
        end
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        n_checks++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: awready %b arready %b, required 1 1",
                s_axi_awready, s_axi_arready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(16'h0010, 8'd5, 8'd0, 2'b01);
        n_checks++;
        if (got_bid !== 8'd5 || got_bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL single_bresp: bid %h bresp %b, required 05 00", got_bid, got_bresp);
        end
        do_read(16'h0010, 8'd7, 8'd0, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 32'hDEADBEEF || rd_id[0] !== 8'd7 ||
            rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL single_read: data %h rid %h last %b resp %b, required deadbeef 07 1 00",
                rd_data[0], rd_id[0], rd_last[0], rd_resp[0]);
        end
        n_checks++;
        if (lat !== 0) begin
            n_fail++;
            $display("FAIL single_latency: first rvalid at cycle %0d, required 0", lat);
        end
        @(negedge clk);
        n_checks++;
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: arready %b rvalid %b, required 1 0",
                s_axi_arready, s_axi_rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_incr_stall();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(16'h0100, 8'd1, 8'd3, 2'b01);
        do_read(16'h0100, 8'd2, 8'd3, 2'b01, 1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL incr_beat%0d: data %h last %b, required %h %b",
                    i, rd_data[i], rd_last[i], 32'(i + 1), (i == 3));
            end
        end
        n_checks++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL incr_stall_stable: %0d changes under stall, required 0", unstable);
        end
    endtask

    task automatic test_back_to_back();
        do_read(16'h0100, 8'd3, 8'd3, 2'b01, 0);
        n_checks++;
        if (cycles !== 4 || rd_data[3] !== 32'd4) begin
            n_fail++;
            $display("FAIL back_to_back: %0d cycles last %h, required 4 00000004",
                cycles, rd_data[3]);
        end
    endtask

    task automatic test_strobe();
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(16'h0300, 8'd0, 8'd0, 2'b01);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(16'h0300, 8'd0, 8'd0, 2'b01);
        do_read(16'h0300, 8'd0, 8'd0, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL strobe: got %h, required 11bb33dd", rd_data[0]);
        end
    endtask

    task automatic test_fixed();
        wd[0] = 32'h5555AAAA; ws[0] = 4'hF;
        do_write(16'h0204, 8'd0, 8'd0, 2'b01);
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        do_write(16'h0200, 8'd0, 8'd2, 2'b00);
        do_read(16'h0200, 8'd0, 8'd0, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 32'hC) begin
            n_fail++;
            $display("FAIL fixed_target: got %h, required 0000000c", rd_data[0]);
        end
        do_read(16'h0204, 8'd0, 8'd0, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 32'h5555AAAA) begin
            n_fail++;
            $display("FAIL fixed_neighbour: got %h, required 5555aaaa", rd_data[0]);
        end
    endtask

    task automatic test_addr_wrap();
        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002;
        ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(16'hFFFC, 8'd0, 8'd1, 2'b01);
        do_read(16'h0000, 8'd0, 8'd0, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 32'hCAFE0002) begin
            n_fail++;
            $display("FAIL wrap_low: got %h, required cafe0002", rd_data[0]);
        end
        do_read(16'hFFFC, 8'd0, 8'd1, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 32'hCAFE0001 || rd_data[1] !== 32'hCAFE0002) begin
            n_fail++;
            $display("FAIL wrap_read: got %h %h, required cafe0001 cafe0002",
                rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_collision();
        wd[0] = 32'h01010101; ws[0] = 4'hF;
        do_write(16'h0400, 8'd0, 8'd0, 2'b01);
        wd[0] = 32'h02020202;
        // W beat and AR accept land on the same clock edge
        fork
            do_write(16'h0400, 8'd0, 8'd0, 2'b01);
            begin @(posedge clk); #1 do_read(16'h0400, 8'd0, 8'd0, 2'b01, 0); end
        join
        n_checks++;
        if (rd_data[0] !== 32'h01010101) begin
            n_fail++;
            $display("FAIL collision_old: got %h, required 01010101", rd_data[0]);
        end
        do_read(16'h0400, 8'd0, 8'd0, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 32'h02020202) begin
            n_fail++;
            $display("FAIL collision_new: got %h, required 02020202", rd_data[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int t;
        s_axi_araddr = 16'h0100; s_axi_arid = 8'd9;
        s_axi_arlen = 8'd7; s_axi_arburst = 2'b01; s_axi_arvalid = 1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_arready && t < 50);
        @(posedge clk); #1 s_axi_arvalid = 0;
        @(negedge clk);
        n_checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'd1) begin
            n_fail++;
            $display("FAIL midrst_start: rvalid %b data %h, required 1 00000001",
                s_axi_rvalid, s_axi_rdata);
        end
        @(posedge clk); #2 rst = 0;
        #1;
        n_checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0 || s_axi_rlast !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: rvalid %b arready %b rlast %b, required 0 0 0",
                s_axi_rvalid, s_axi_arready, s_axi_rlast);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        n_checks++;
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: arready %b rvalid %b, required 1 0",
                s_axi_arready, s_axi_rvalid);
        end
        @(posedge clk); #1;
        do_read(16'h0010, 8'd0, 8'd0, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL midrst_retain: got %h, required deadbeef", rd_data[0]);
        end
        do_read(16'h0100, 8'd0, 8'd3, 2'b01, 0);
        n_checks++;
        if (rd_data[0] !== 32'd1 || rd_data[3] !== 32'd4 || rd_last[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_burst: got %h %h last %b, required 00000001 00000004 1",
                rd_data[0], rd_data[3], rd_last[3]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr_stall();
        test_back_to_back();
        test_strobe();
        test_fixed();
        test_addr_wrap();
        test_collision();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
